uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- UART transmitter: serialises one 8-bit byte per request into a standard 8N1 asynchronous frame on a single output line.
- Frame order: start bit, 8 data bits LSB first, 1 stop bit.
- Bit period is a fixed number of system clocks; no baud-rate generator is needed outside the block.
- Sits between a byte-producing controller and the UART TX pin.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range ≥ 2; frame length = 10*CLKS_PER_BIT cycles.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- send  input  1  transmit request, level-sampled on each rising edge.
- data  input  8  byte to transmit; sampled only on the accepting edge.
- dout  output  1  serial line; idle high.
- busy  output  1  high while a frame is in progress (START..STOP).

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, dout = 1, busy = 0.
  - Bit counter and cycle counter = 0; shift register = 0.
  - A reset mid-frame aborts the frame immediately, with dout returning high.
- States: IDLE, START, DATA, STOP.
- All outputs are registered.
- IDLE:
  - dout = 1, busy = 0.
  - On a rising edge with send = 1, the block accepts the request:
    - data is latched into the shift register.
    - The cycle counter is cleared.
    - state → START; dout = 0 and busy = 1 from that same edge.
  - No latency cycle: dout falls on the accepting edge.
- data may change or drop on any cycle after the accepting edge without affecting the frame.
- send may stay high or fall at any time after acceptance; it is ignored outside IDLE.
- START:
  - dout = 0 for exactly CLKS_PER_BIT cycles.
  - Then state → DATA, bit index = 0, dout = shift[0].
- DATA:
  - Each bit is held for exactly CLKS_PER_BIT cycles.
  - The shift register moves right (or the index increments) so bits go out in order data[0] .. data[7].
  - After bit 7's period: state → STOP, dout = 1.
- STOP:
  - dout = 1 for exactly CLKS_PER_BIT cycles.
  - Then state → IDLE, busy = 0.
- Frame length: exactly 10*CLKS_PER_BIT clocks from the accepting edge to the edge that returns to IDLE (160 at the default).
- Back-to-back frames:
  - send is sampled again only once in IDLE, so at least one idle cycle (dout high) separates frames.
  - If send is held high continuously, a new frame (re-latching data) starts on the first IDLE edge.
- Counters:
  - Cycle counter width is clog2(CLKS_PER_BIT).
  - It counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - Bit index counts 0..7.
- No glitches on dout; it changes only on clk rising edges, or asynchronously at reset.

Test Plan:
- Reset: assert rst_n low, clk 100 MHz → dout = 1, busy = 0; release rst_n with send = 0 → dout stays 1 indefinitely.
- Single frame, default CLKS_PER_BIT = 16:
  - Stimulus: data = 0x6C valid from 10 ns to 30 ns; send high from 22 ns to 52 ns; first sampling edge at 25 ns.
  - Required dout: low 25–185 ns (start), then bits 0,0,1,1,0,1,1,0 each 160 ns, then high 1465–1625 ns (stop).
  - Required busy: high 25–1625 ns.
  - data changing to 0 at 30 ns must not corrupt the frame.
- Send held high for 3 frames, data = 0xA5:
  - Required: three identical frames 0, 1,0,1,0,0,1,0,1, 1.
  - Each frame is 160 cycles; exactly one idle-high cycle between frames.
- Send pulses during busy, with different data (e.g. 0xFF at mid-frame): ignored; frame content unchanged; no extra frame afterwards.
- Reset mid-frame (rst_n low during bit 3): dout = 1 and busy = 0 immediately; after release the line stays idle until a new send.
- CLKS_PER_BIT = 4 with data = 0x00: start plus 8 data bits give 36 cycles low, then 4 cycles high; total frame 40 cycles.

Source files
------------

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx : 8N1 asynchronous serial transmitter.
//
// Sends one byte per accepted request as a frame of start bit (0), eight data
// bits LSB first, and stop bit (1). Each bit lasts CLKS_PER_BIT clocks, so a
// frame takes 10*CLKS_PER_BIT clocks. A request is taken the moment the block
// is idle, and dout falls on that same edge.
//
// Ports
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset (aborts any frame, line idles high)
//   send   in   transmit request, sampled every edge, honoured only when idle
//   data   in   byte to send, captured on the accepting edge only
//   dout   out  serial line, idle high, registered
//   busy   out  high from the accepting edge until the frame's last edge
// -----------------------------------------------------------------------------
module uart_tx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       send,
   input  logic [7:0] data,
   output logic       dout,
   output logic       busy
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic [2:0]    bit_q,   bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          dout_q,  dout_d;
   logic          busy_q,  busy_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         dout_q  <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         dout_q  <= dout_d;
         busy_q  <= busy_d;
      end
   end

   // dout/busy are computed one edge ahead so that they come straight from
   // flops; the value assigned here is what the line shows after this edge.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      dout_d  = dout_q;
      busy_d  = busy_q;

      unique case (state_q)
         IDLE: begin
            dout_d = 1'b1;
            busy_d = 1'b0;
            if (send) begin
               shift_d = data;
               cnt_d   = '0;
               state_d = START;
               dout_d  = 1'b0;
               busy_d  = 1'b1;
            end
         end
         START: begin
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = DATA;
               dout_d  = shift_q[0];
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DATA: begin
            if (cnt_q == LAST) begin
               cnt_d = '0;
               if (bit_q == 3'd7) begin
                  state_d = STOP;
                  dout_d  = 1'b1;
               end else begin
                  // shift_q[0] is the bit on the line; the next one is [1]
                  bit_d   = bit_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
                  dout_d  = shift_q[1];
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         STOP: begin
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               state_d = IDLE;
               dout_d  = 1'b1;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            dout_d  = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign dout = dout_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx : checks two uart_tx instances (CLKS_PER_BIT 16 and 4) against a
// frame-position reference model: after acceptance, cycle k of the frame shows
// slot k/CLKS_PER_BIT of {start, d0..d7, stop}; the frame is 10 slots long.
// -----------------------------------------------------------------------------
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       send16, send4;
   logic [7:0] data16, data4;
   logic       dout16, busy16, dout4, busy4;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   uart_tx #(.CLKS_PER_BIT(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .send(send16), .data(data16),
      .dout(dout16), .busy(busy16));

   uart_tx #(.CLKS_PER_BIT(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .send(send4), .data(data4),
      .dout(dout4), .busy(busy4));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int         cpb [2] = '{16, 4};
   logic       m_act [2];
   int         m_k   [2];
   logic [7:0] m_byte[2];
   logic       snd [2];
   logic [7:0] dat [2];

   assign snd[0] = send16;
   assign snd[1] = send4;
   assign dat[0] = data16;
   assign dat[1] = data4;

   function automatic logic line_at(input logic [7:0] b, input int k, input int c);
      int slot;
      slot = k / c;
      if (slot == 0) return 1'b0;
      if (slot <= 8) return b[slot-1];
      return 1'b1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            m_act[i] <= 1'b0;
            m_k[i]   <= 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (!m_act[i]) begin
               if (snd[i]) begin
                  m_act[i]  <= 1'b1;
                  m_k[i]    <= 0;
                  m_byte[i] <= dat[i];
               end
            end else begin
               m_k[i]   <= m_k[i] + 1;
               m_act[i] <= (m_k[i] + 1 != 10 * cpb[i]);
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("dout16", 32'(dout16), 32'(m_act[0] ? line_at(m_byte[0], m_k[0], cpb[0]) : 1'b1));
      chk("busy16", 32'(busy16), 32'(m_act[0]));
      chk("dout4",  32'(dout4),  32'(m_act[1] ? line_at(m_byte[1], m_k[1], cpb[1]) : 1'b1));
      chk("busy4",  32'(busy4),  32'(m_act[1]));
   end

   // ---------------- stimulus ----------------
   int idle_cnt, low_cnt, busy_cnt;
   logic [7:0] b6c;

   initial begin
      send16 = 1'b0; data16 = 8'h00; send4 = 1'b0; data4 = 8'h00;
      rst_n  = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_dout16", 32'(dout16), 32'd1);
      chk("rst_busy16", 32'(busy16), 32'd0);
      chk("rst_dout4",  32'(dout4),  32'd1);
      chk("rst_busy4",  32'(busy4),  32'd0);
      #5 rst_n = 1'b1;                          // t = 8

      // timed single frame, 0x6C, accepted on the 25 ns edge
      #2  data16 = 8'h6C;                       // t = 10
      #12 send16 = 1'b1;                        // t = 22
      #8  data16 = 8'h00;                       // t = 30
      #22 send16 = 1'b0;                        // t = 52
      #48;                                      // t = 100
      chk("t_start_dout", 32'(dout16), 32'd0);
      chk("t_start_busy", 32'(busy16), 32'd1);
      b6c = 8'h6C;
      #165;                                     // t = 265, middle of bit 0
      for (int i = 0; i < 8; i++) begin
         chk("t_bit", 32'(dout16), 32'(b6c[i]));
         chk("t_bit_busy", 32'(busy16), 32'd1);
         #160;
      end                                       // t = 1545, middle of stop
      chk("t_stop_dout", 32'(dout16), 32'd1);
      chk("t_stop_busy", 32'(busy16), 32'd1);
      #85;                                      // t = 1630
      chk("t_end_busy", 32'(busy16), 32'd0);
      chk("t_end_dout", 32'(dout16), 32'd1);

      // send held high for three frames of 0xA5
      @(negedge clk);
      data16 = 8'hA5; send16 = 1'b1;
      @(negedge clk);
      idle_cnt = 0;
      repeat (482) begin
         if (!busy16) idle_cnt++;
         @(negedge clk);
      end
      send16 = 1'b0;
      chk("held_idle_gaps", 32'(idle_cnt), 32'd2);
      repeat (5) @(negedge clk);

      // request with 0xFF in mid-frame is ignored
      data16 = 8'h3C; send16 = 1'b1;
      @(negedge clk);
      send16 = 1'b0; data16 = 8'($urandom);
      repeat (80) @(negedge clk);
      send16 = 1'b1; data16 = 8'hFF;
      @(negedge clk);
      send16 = 1'b0;
      repeat (100) @(negedge clk);
      chk("no_extra_frame", 32'(busy16), 32'd0);

      // CLKS_PER_BIT = 4, data 0x00: 36 low, 4 high, 40 busy
      data4 = 8'h00; send4 = 1'b1;
      @(negedge clk);
      send4 = 1'b0; data4 = 8'hFF;
      low_cnt = 0; busy_cnt = 0;
      repeat (40) begin
         if (!dout4) low_cnt++;
         if (busy4) busy_cnt++;
         @(negedge clk);
      end
      chk("cpb4_low", 32'(low_cnt), 32'd36);
      chk("cpb4_busy", 32'(busy_cnt), 32'd40);
      chk("cpb4_done", 32'(busy4), 32'd0);

      // reset during bit 3
      data16 = 8'h55; send16 = 1'b1;
      @(negedge clk);
      send16 = 1'b0;
      repeat (72) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_dout", 32'(dout16), 32'd1);
      chk("midrst_busy", 32'(busy16), 32'd0);
      #10 rst_n = 1'b1;
      repeat (50) @(negedge clk);
      chk("post_rst_idle", 32'(busy16), 32'd0);

      // random traffic
      repeat (3000) begin
         @(negedge clk);
         send16 = ($urandom_range(39) == 0);
         data16 = 8'($urandom);
         send4  = ($urandom_range(11) == 0);
         data4  = 8'($urandom);
      end
      send16 = 1'b0; send4 = 1'b0;
      repeat (200) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
